// File: rtl/zle_pkg.sv
// rtl/zle_pkg.sv - token fields and state encodings shared by the ZLE encoder and decoder
package zle_pkg;

   localparam int DATA_W      = 3;
   localparam int TOK_W       = DATA_W + 1;
   localparam int TOK_RUN_BIT = DATA_W;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/zld_stream_if.sv
// rtl/zld_stream_if.sv - valid/ready stream bundle used on both sides of the decoder
interface zld_stream_if #(
   parameter int W = 4
);

   logic [W-1:0] d;
   logic         v;
   logic         r;

   modport master (output d, v, input r);
   modport slave  (input d, v, output r);

endinterface

// File: rtl/zld_dp.sv
// rtl/zld_dp.sv - decoder datapath: run counter and output sample register
import zle_pkg::*;

module zld_dp #(
   parameter int DATA_W = zle_pkg::DATA_W
) (
   input  logic              clock,
   input  logic              reset,
   input  state_t            state,
   input  logic              fire,
   input  logic              ld,
   input  logic [DATA_W:0]   tok,
   output logic [DATA_W-1:0] o_d,
   output logic              o_v,
   output logic              cnt_eq_1
);

   logic [DATA_W-1:0] cnt;

   assign cnt_eq_1 = (cnt == DATA_W'(1));

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt <= '0;
         o_d <= '0;
         o_v <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (fire) begin
                  o_v <= 1'b1;
                  if (tok[DATA_W]) begin
                     o_d <= '0;
                     cnt <= tok[DATA_W-1:0];
                  end else begin
                     o_d <= tok[DATA_W-1:0];
                  end
               end else if (ld) begin
                  o_v <= 1'b0;
               end
            end
            S_RUN: begin
               // The first zero of a run was loaded on acceptance, so cnt zeros remain.
               if (ld) begin
                  o_d <= '0;
                  o_v <= 1'b1;
                  cnt <= cnt - DATA_W'(1);
               end
            end
            default: o_v <= 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/zld_stream.sv
// rtl/zld_stream.sv - zero run-length decoder: expands run tokens into zero samples
import zle_pkg::*;

module zld_stream #(
   parameter int DATA_W = zle_pkg::DATA_W
) (
   input  logic         clock,
   input  logic         reset,
   zld_stream_if.slave  in_s,
   zld_stream_if.master out_m,
   output logic         run_act
);

   state_t            state;
   logic              ld;
   logic              fire;
   logic              cnt_eq_1;
   logic [DATA_W-1:0] dp_d;
   logic              dp_v;

   assign ld      = !dp_v || out_m.r;
   assign in_s.r  = (state == S_IDLE) && ld;
   assign fire    = in_s.v && in_s.r;
   assign run_act = (state == S_RUN);

   assign out_m.d = dp_d;
   assign out_m.v = dp_v;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               // A zero-count run is a single zero and needs no S_RUN visit.
               if (fire && in_s.d[DATA_W] && (in_s.d[DATA_W-1:0] != '0))
                  state <= S_RUN;
            end
            S_RUN: begin
               if (ld && cnt_eq_1)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   zld_dp #(.DATA_W(DATA_W)) u_dp (
      .clock    (clock),
      .reset    (reset),
      .state    (state),
      .fire     (fire),
      .ld       (ld),
      .tok      (in_s.d),
      .o_d      (dp_d),
      .o_v      (dp_v),
      .cnt_eq_1 (cnt_eq_1)
   );

endmodule

// File: tb/tb_zld_stream.sv
// tb/tb_zld_stream.sv - directed vector table, reset/run corners and random scoreboard for zld_stream
module tb_zld_stream;

   logic clock;
   logic reset;
   logic run_act;

   zld_stream_if #(.W(4)) in_if ();
   zld_stream_if #(.W(3)) out_if ();

   zld_stream #(.DATA_W(3)) dut (
      .clock   (clock),
      .reset   (reset),
      .in_s    (in_if.slave),
      .out_m   (out_if.master),
      .run_act (run_act)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [3:0] tok;
      logic       v;
      logic       rdy;
      logic       e_ir;
      logic       e_ov;
      logic [2:0] e_od;
      logic       e_run;
   } vec_t;

   vec_t       vecs[$];
   int         total = 0;
   int         bad   = 0;
   logic [2:0] exp_q[$];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic void add(input logic [3:0] tok, input logic v, input logic rdy,
                               input logic e_ir, input logic e_ov, input logic [2:0] e_od,
                               input logic e_run);
      vecs.push_back('{tok, v, rdy, e_ir, e_ov, e_od, e_run});
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      in_if.v   = 1'b0;
      in_if.d   = '0;
      out_if.r  = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      logic       hold_prev;
      logic [2:0] prev_d;
      logic [2:0] exp_d;
      int         n;

      reset    = 1'b1;
      in_if.v  = 1'b0;
      in_if.d  = '0;
      out_if.r = 1'b0;
      tick();
      tick();
      chk("reset_o_v", int'(out_if.v), 0);
      chk("reset_o_d", int'(out_if.d), 0);
      chk("reset_run_act", int'(run_act), 0);
      reset = 1'b0;

      // tok, v, o_r, exp i_r (this cycle), exp o_v/o_d/run_act (after edge)
      add(4'b0011, 1, 1, 1, 1, 3'd3, 0);
      add(4'b0101, 1, 1, 1, 1, 3'd5, 0);
      add(4'b0000, 1, 1, 1, 1, 3'd0, 0);
      add(4'b0111, 1, 1, 1, 1, 3'd7, 0);
      add(4'b1000, 1, 1, 1, 1, 3'd0, 0);
      add(4'b0110, 1, 1, 1, 1, 3'd6, 0);
      add(4'b1111, 1, 1, 1, 1, 3'd0, 1);
      for (int i = 0; i < 6; i++) add(4'b0010, 1, 1, 0, 1, 3'd0, 1);
      add(4'b0010, 1, 1, 0, 1, 3'd0, 0);
      add(4'b0010, 1, 1, 1, 1, 3'd2, 0);
      add(4'b0000, 0, 1, 1, 0, 3'd2, 0);
      add(4'b1010, 1, 1, 1, 1, 3'd0, 1);
      add(4'b0001, 0, 0, 0, 1, 3'd0, 1);
      add(4'b0001, 0, 0, 0, 1, 3'd0, 1);
      add(4'b0001, 0, 1, 0, 1, 3'd0, 1);
      add(4'b0001, 0, 1, 0, 1, 3'd0, 0);
      add(4'b0001, 0, 1, 1, 0, 3'd0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         in_if.d  = vecs[i].tok;
         in_if.v  = vecs[i].v;
         out_if.r = vecs[i].rdy;
         #1;
         chk($sformatf("vec%0d_i_r", i), int'(in_if.r), int'(vecs[i].e_ir));
         tick();
         chk($sformatf("vec%0d_o_v", i), int'(out_if.v), int'(vecs[i].e_ov));
         chk($sformatf("vec%0d_o_d", i), int'(out_if.d), int'(vecs[i].e_od));
         chk($sformatf("vec%0d_run_act", i), int'(run_act), int'(vecs[i].e_run));
      end

      // Reset in the middle of an 8-zero run, after two zeros have been loaded.
      in_if.d  = 4'b1111;
      in_if.v  = 1'b1;
      out_if.r = 1'b1;
      tick();
      in_if.v = 1'b0;
      tick();
      chk("midrun_run_act_before", int'(run_act), 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("midrun_o_v", int'(out_if.v), 0);
      chk("midrun_run_act", int'(run_act), 0);
      chk("midrun_i_r", int'(in_if.r), 1);
      in_if.d = 4'b0100;
      in_if.v = 1'b1;
      tick();
      chk("post_reset_o_v", int'(out_if.v), 1);
      chk("post_reset_o_d", int'(out_if.d), 4);
      in_if.v = 1'b0;
      tick();
      chk("post_reset_drained", int'(out_if.v), 0);

      // Random tokens and back-pressure checked against a reference expansion.
      do_reset();
      hold_prev = 1'b0;
      prev_d    = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         in_if.v  = (cyc < 360) && ($urandom_range(3) != 0);
         in_if.d  = 4'($urandom_range(15));
         out_if.r = (cyc >= 360) || ($urandom_range(3) != 0);
         #1;
         if (hold_prev) begin
            chk("rand_hold_o_v", int'(out_if.v), 1);
            chk("rand_hold_o_d", int'(out_if.d), int'(prev_d));
         end
         if (out_if.v && out_if.r) begin
            if (exp_q.size() == 0) begin
               chk("rand_unexpected_sample", 1, 0);
            end else begin
               exp_d = exp_q.pop_front();
               chk("rand_o_d", int'(out_if.d), int'(exp_d));
            end
         end
         if (in_if.v && in_if.r) begin
            if (in_if.d[3]) begin
               n = int'(in_if.d[2:0]) + 1;
               for (int k = 0; k < n; k++) exp_q.push_back(3'd0);
            end else begin
               exp_q.push_back(in_if.d[2:0]);
            end
         end
         hold_prev = out_if.v && !out_if.r;
         prev_d    = out_if.d;
         tick();
      end
      chk("rand_queue_drained", exp_q.size(), 0);
      chk("rand_final_o_v", int'(out_if.v), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
